pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit.sv | 120 ++++++++++++
 tb/tb_pc_stack_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with a small hardware return stack for call/return.
// One command per clock edge, priority ret > call > lp > cp; sticky overflow/underflow flags.
module pc_stack_unit #(
  parameter int                ADDR_W    = 4,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cp,
  input  logic                         lp,
  input  logic                         ep,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         err_clr,
  input  logic [ADDR_W-1:0]            bus_in,
  output logic [ADDR_W-1:0]            bus_out,
  output logic [ADDR_W-1:0]            pc,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf,
  output logic                         unf
);

  localparam int SP_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0]       pc_reg, pc_next;
  logic [SP_W-1:0]         sp_reg, sp_next;
  logic                    ovf_reg, ovf_next;
  logic                    unf_reg, unf_next;
  logic                    push_en;
  logic                    ovf_evt, unf_evt;
  logic                    full_w, empty_w;
  logic [ADDR_W-1:0]       ret_addr;
  logic [SP_W-1:0]         pop_idx;
  logic [ADDR_W-1:0]       pop_data;
  logic [DEPTH*ADDR_W-1:0] stack_flat;

  assign full_w   = (sp_reg == SP_W'(DEPTH));
  assign empty_w  = (sp_reg == '0);
  assign ret_addr = pc_reg + ADDR_W'(1);
  assign pop_idx  = sp_reg - SP_W'(1);

  // Stack entries carry no reset: anything at or above sp is never read.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stack
      logic [ADDR_W-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push_en && (sp_reg == SP_W'(gi)))
          entry_reg <= ret_addr;
      end
      assign stack_flat[gi*ADDR_W +: ADDR_W] = entry_reg;
    end
  endgenerate

  always_comb begin
    pop_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pop_idx == SP_W'(i))
        pop_data = stack_flat[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    pc_next = pc_reg;
    sp_next = sp_reg;
    push_en = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (ret) begin
      if (!empty_w) begin
        pc_next = pop_data;
        sp_next = sp_reg - SP_W'(1);
      end else begin
        unf_evt = 1'b1;
      end
    end else if (call) begin
      if (!full_w) begin
        push_en = 1'b1;
        pc_next = bus_in;
        sp_next = sp_reg + SP_W'(1);
      end else begin
        ovf_evt = 1'b1;
      end
    end else if (lp) begin
      pc_next = bus_in;
    end else if (cp) begin
      pc_next = pc_reg + ADDR_W'(1);
    end
  end

  // A new event on the same edge as err_clr leaves its flag set.
  assign ovf_next = (ovf_reg & ~err_clr) | ovf_evt;
  assign unf_next = (unf_reg & ~err_clr) | unf_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg  <= RESET_VEC;
      sp_reg  <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      sp_reg  <= sp_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  assign pc      = pc_reg;
  assign sp      = sp_reg;
  assign full    = full_w;
  assign empty   = empty_w;
  assign ovf     = ovf_reg;
  assign unf     = unf_reg;
  assign bus_out = ep ? pc_reg : '0;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: queue-based reference model checked every
// falling edge, plus literal expectations at key points of each scenario.
module tb_pc_stack_unit;

  localparam int          ADDR_W = 4;
  localparam int          DEPTH  = 4;
  localparam logic [3:0]  RV     = 4'd0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cp = 0, lp = 0, ep = 0, call = 0, ret = 0, err_clr = 0;
  logic [3:0] bus_in = '0;
  logic [3:0] bus_out, pc;
  logic [2:0] sp;
  logic       full, empty, ovf, unf;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 0;

  pc_stack_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_VEC(RV)) dut (
    .clk(clk), .rst(rst), .cp(cp), .lp(lp), .ep(ep), .call(call), .ret(ret),
    .err_clr(err_clr), .bus_in(bus_in), .bus_out(bus_out), .pc(pc), .sp(sp),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Reference model: return stack as a queue of addresses.
  int m_pc;
  int m_q[$];
  bit m_ovf, m_unf;

  always @(posedge clk or posedge rst) begin
    bit oe, ue;
    oe = 0;
    ue = 0;
    if (rst) begin
      m_pc = int'(RV);
      m_q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (ret) begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else ue = 1;
      end else if (call) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back((m_pc + 1) % 16);
          m_pc = int'(bus_in);
        end else oe = 1;
      end else if (lp) begin
        m_pc = int'(bus_in);
      end else if (cp) begin
        m_pc = (m_pc + 1) % 16;
      end
      if (err_clr) begin
        m_ovf = 0;
        m_unf = 0;
      end
      if (oe) m_ovf = 1;
      if (ue) m_unf = 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model pc", int'(pc), m_pc);
      chk("model sp", int'(sp), m_q.size());
      chk("model full", int'(full), int'(m_q.size() == DEPTH));
      chk("model empty", int'(empty), int'(m_q.size() == 0));
      chk("model ovf", int'(ovf), int'(m_ovf));
      chk("model unf", int'(unf), int'(m_unf));
      chk("model bus_out", int'(bus_out), ep ? m_pc : 0);
    end
  end

  // Apply one command for one edge; returns 1 time unit after the edge.
  task automatic cyc(input logic c, input logic l, input logic ca, input logic r,
                     input logic e, input logic [3:0] b);
    cp = c; lp = l; call = ca; ret = r; err_clr = e; bus_in = b;
    @(posedge clk);
    #1;
    $display("cmd cp=%0b lp=%0b call=%0b ret=%0b clr=%0b bus_in=%0d -> pc=%0d sp=%0d ovf=%0b unf=%0b",
             c, l, ca, r, e, b, pc, sp, ovf, unf);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    ep = 1;
    #1;
    chk("reset pc", int'(pc), 0);
    chk("reset sp", int'(sp), 0);
    chk("reset empty", int'(empty), 1);
    chk("reset full", int'(full), 0);
    chk("reset flags", int'({ovf, unf}), 0);
    chk("reset bus_out", int'(bus_out), 0);
    ep = 0;
    rst = 0;
    chk_en = 1;

    // cp held 17 cycles: 0..15,0,1
    chk("cp start", int'(pc), 0);
    for (int k = 1; k <= 17; k++) begin
      cyc(1, 0, 0, 0, 0, 4'd0);
      chk("cp seq", int'(pc), k % 16);
    end
    chk("cp no flags", int'({ovf, unf}), 0);

    // idle hold
    cyc(0, 0, 0, 0, 0, 4'd7);
    chk("idle hold", int'(pc), 1);

    // call/ret round trip
    cyc(0, 1, 0, 0, 0, 4'd3);
    chk("lp 3", int'(pc), 3);
    cyc(0, 0, 1, 0, 0, 4'd9);
    chk("call pc", int'(pc), 9);
    chk("call sp", int'(sp), 1);
    ep = 1;
    #1;
    chk("ep bus_out", int'(bus_out), 9);
    ep = 0;
    #1;
    chk("ep off bus_out", int'(bus_out), 0);
    cyc(0, 0, 0, 1, 0, 4'd0);
    chk("ret pc", int'(pc), 4);
    chk("ret empty", int'(empty), 1);

    // Five calls from pc=0 into a depth-4 stack
    cyc(0, 1, 0, 0, 0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 1, 0, 0, 4'(k));
      if (k == 4) begin
        chk("fourth call pc", int'(pc), 4);
        chk("fourth call full", int'(full), 1);
        chk("fourth call ovf", int'(ovf), 0);
      end
    end
    chk("overflow pc", int'(pc), 4);
    chk("overflow sp", int'(sp), 4);
    chk("overflow ovf", int'(ovf), 1);
    cyc(0, 0, 0, 0, 1, 4'd0);
    chk("ovf cleared", int'(ovf), 0);
    for (int k = 4; k >= 1; k--) begin
      cyc(0, 0, 0, 1, 0, 4'd0);
      chk("unwind pc", int'(pc), k);
    end
    chk("unwind sp", int'(sp), 0);

    // Underflow, clear, and set-wins
    cyc(0, 0, 0, 1, 0, 4'd0);
    chk("unf pc held", int'(pc), 1);
    chk("unf set", int'(unf), 1);
    cyc(0, 0, 0, 0, 1, 4'd0);
    chk("unf cleared", int'(unf), 0);
    cyc(0, 0, 0, 1, 1, 4'd0);
    chk("unf set wins", int'(unf), 1);
    cyc(0, 0, 0, 0, 1, 4'd0);

    // All commands together: ret wins
    cyc(0, 1, 0, 0, 0, 4'd5);
    cyc(0, 0, 1, 0, 0, 4'd0);
    chk("setup sp", int'(sp), 1);
    cyc(1, 1, 1, 1, 0, 4'd2);
    chk("priority pc", int'(pc), 6);
    chk("priority sp", int'(sp), 0);

    // Asynchronous reset mid-cycle after two calls
    cyc(0, 0, 0, 1, 0, 4'd0);
    cyc(0, 1, 0, 0, 0, 4'd7);
    cyc(0, 0, 1, 0, 0, 4'd10);
    cyc(0, 0, 1, 0, 0, 4'd12);
    chk("pre-reset pc", int'(pc), 12);
    chk("pre-reset sp", int'(sp), 2);
    chk("pre-reset unf", int'(unf), 1);
    cp = 0; lp = 0; call = 0; ret = 0; err_clr = 0;
    ep = 1;
    #2;
    rst = 1;
    #1;
    chk("async rst pc", int'(pc), int'(RV));
    chk("async rst sp", int'(sp), 0);
    chk("async rst flags", int'({ovf, unf}), 0);
    chk("async rst bus_out", int'(bus_out), int'(RV));
    chk("async rst empty", int'(empty), 1);
    @(posedge clk);
    #1;
    rst = 0;
    ep = 0;
    cyc(1, 0, 0, 0, 0, 4'd0);
    chk("post-reset cp", int'(pc), 1);

    @(negedge clk);
    #1;
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
